// File: rtl/instr_fetch_decode_if.sv
// Bundles the start/fetch/decoded-output signals of instr_fetch_decode.
// master = the fetch/decode block, slave = its environment (memory, consumer, controller).
interface instr_fetch_decode_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] pc_out;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, count, mem_rdata, out_ready,
    output mem_read, mem_addr, out_valid, pc_out, fmt, opcode, rs, rt, rd, shamt, funct,
           imm, target, busy, done
  );

  modport slave (
    output start, base_addr, count, mem_rdata, out_ready,
    input  mem_read, mem_addr, out_valid, pc_out, fmt, opcode, rs, rt, rd, shamt, funct,
           imm, target, busy, done
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Sequential instruction fetch and MIPS-style field decode with a valid/ready output.
// Optional FETCH_JUMP_FOLLOW_EN: accepted J-type words redirect the next fetch to their target.
module instr_fetch_decode #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned STRIDE  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_fetch_decode_if.master bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StPresent, StDone} state_e;

  localparam logic [1:0] FmtR   = 2'd0;
  localparam logic [1:0] FmtI   = 2'd1;
  localparam logic [1:0] FmtJ   = 2'd2;
  localparam logic [1:0] FmtUnk = 2'd3;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [CNT_W-1:0]  rem_q;
  logic [2:0]        lat_q;
  logic [31:0]       ir_q;
  logic [1:0]        fmt_q;
  logic              mem_read_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] pc_step;
  logic [ADDR_W-1:0] pc_next;

  function automatic logic [1:0] decode_fmt(input logic [5:0] op);
    case (op)
      6'd0:                                     return FmtR;
      6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12,
      6'd13, 6'd14, 6'd15, 6'd35, 6'd43:        return FmtI;
      6'd2, 6'd3:                               return FmtJ;
      default:                                  return FmtUnk;
    endcase
  endfunction

  assign pc_step = pc_q + ADDR_W'(STRIDE);

`ifdef FETCH_JUMP_FOLLOW_EN
  logic [ADDR_W-1:0] pc_plus4;

  // Jump target keeps the upper bits of the delay-slot address, not of pc+STRIDE.
  always_comb begin
    pc_plus4 = pc_q + ADDR_W'(4);
    pc_next  = pc_step;
    if (fmt_q == FmtJ) begin
      pc_next       = pc_plus4;
      pc_next[27:0] = {ir_q[25:0], 2'b00};
    end
  end
`else
  assign pc_next = pc_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      pc_out_q    <= '0;
      rem_q       <= '0;
      lat_q       <= '0;
      ir_q        <= '0;
      fmt_q       <= '0;
      mem_read_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_read_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              pc_q       <= bus.base_addr;
              rem_q      <= bus.count;
              mem_read_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= StIssue;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          lat_q   <= 3'(MEM_LAT);
          state_q <= StWait;
        end
        StWait: begin
          if (lat_q == 3'd0) begin
            ir_q        <= bus.mem_rdata;
            fmt_q       <= decode_fmt(bus.mem_rdata[31:26]);
            pc_out_q    <= pc_q;
            out_valid_q <= 1'b1;
            state_q     <= StPresent;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        StPresent: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            rem_q       <= rem_q - CNT_W'(1);
            pc_q        <= pc_next;
            if (rem_q == CNT_W'(1)) begin
              // busy drops together with the done pulse.
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              mem_read_q <= 1'b1;
              state_q    <= StIssue;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_addr  = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pc_out    = pc_out_q;
  assign bus.fmt       = fmt_q;
  assign bus.opcode    = ir_q[31:26];
  assign bus.rs        = ir_q[25:21];
  assign bus.rt        = ir_q[20:16];
  assign bus.rd        = ir_q[15:11];
  assign bus.shamt     = ir_q[10:6];
  assign bus.funct     = ir_q[5:0];
  assign bus.imm       = ir_q[15:0];
  assign bus.target    = ir_q[25:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboard bench for instr_fetch_decode: expected words and fetch addresses are queued
// by the stimulus and consumed by negedge monitors.
module tb_instr_fetch_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_decode_if #(.ADDR_W(32), .CNT_W(8)) ifc ();
  instr_fetch_decode_if #(.ADDR_W(32), .CNT_W(8)) ifc4 ();

  instr_fetch_decode #(.ADDR_W(32), .CNT_W(8), .MEM_LAT(1), .STRIDE(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.master)
  );

  instr_fetch_decode #(.ADDR_W(32), .CNT_W(8), .MEM_LAT(4), .STRIDE(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc4.master)
  );

  logic [31:0] mem [256];
  assign ifc.mem_rdata  = mem[ifc.mem_addr[9:2]];
  assign ifc4.mem_rdata = mem[ifc4.mem_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;
  int n_done   = 0;
  word_t       exp_q[$];
  logic [31:0] addr_q[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Hand-decoded reference words.
  function automatic word_t w_r(input logic [31:0] pc);  // 0x012A4020
    word_t w;
    w.pc = pc; w.fmt = 2'd0; w.opcode = 6'd0; w.rs = 5'd9; w.rt = 5'd10; w.rd = 5'd8;
    w.shamt = 5'd0; w.funct = 6'd32; w.imm = 16'h4020; w.target = 26'h12A4020;
    return w;
  endfunction

  function automatic word_t w_i(input logic [31:0] pc);  // 0x8D090004
    word_t w;
    w.pc = pc; w.fmt = 2'd1; w.opcode = 6'd35; w.rs = 5'd8; w.rt = 5'd9; w.rd = 5'd0;
    w.shamt = 5'd0; w.funct = 6'd4; w.imm = 16'h0004; w.target = 26'h1090004;
    return w;
  endfunction

  function automatic word_t w_j(input logic [31:0] pc);  // 0x08000040
    word_t w;
    w.pc = pc; w.fmt = 2'd2; w.opcode = 6'd2; w.rs = 5'd0; w.rt = 5'd0; w.rd = 5'd0;
    w.shamt = 5'd1; w.funct = 6'd0; w.imm = 16'h0040; w.target = 26'h0000040;
    return w;
  endfunction

  function automatic word_t w_u(input logic [31:0] pc);  // 0xFC000000
    word_t w;
    w.pc = pc; w.fmt = 2'd3; w.opcode = 6'd63; w.rs = 5'd0; w.rt = 5'd0; w.rd = 5'd0;
    w.shamt = 5'd0; w.funct = 6'd0; w.imm = 16'h0000; w.target = 26'h0000000;
    return w;
  endfunction

  function automatic word_t cur_word();
    word_t w;
    w.pc = ifc.pc_out; w.fmt = ifc.fmt; w.opcode = ifc.opcode; w.rs = ifc.rs; w.rt = ifc.rt;
    w.rd = ifc.rd; w.shamt = ifc.shamt; w.funct = ifc.funct; w.imm = ifc.imm;
    w.target = ifc.target;
    return w;
  endfunction

  function automatic logic [159:0] out_vec();
    return 160'({ifc.mem_read, ifc.mem_addr, ifc.out_valid, cur_word(), ifc.busy, ifc.done});
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: actual pc %0h required no word", ifc.pc_out);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("word", 160'(cur_word()), 160'(e));
      end
    end
    if (rst_n && ifc.mem_read) begin
      n_reads++;
      if (addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_fetch: actual addr %0h required no fetch", ifc.mem_addr);
      end else begin
        logic [31:0] a;
        a = addr_q.pop_front();
        check("fetch_addr", 160'(ifc.mem_addr), 160'(a));
      end
    end
    if (rst_n && ifc.done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [7:0] cnt);
    step();
    ifc.start = 1'b1;
    ifc.base_addr = base;
    ifc.count = cnt;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300 && !ifc.done; i++) step();
    check({name, "_done"}, 160'(ifc.done), 160'(1));
    check({name, "_busy_low"}, 160'(ifc.busy), 160'(0));
    step();
    check({name, "_done_one_cycle"}, 160'(ifc.done), 160'(0));
  endtask

  task automatic queues_empty(input string name);
    check({name, "_words_left"}, 160'(exp_q.size()), 160'(0));
    check({name, "_fetches_left"}, 160'(addr_q.size()), 160'(0));
  endtask

  initial begin
    int k;
    int nd;
    int rd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32] = 32'h012A4020;
    mem[33] = 32'h8D090004;
    mem[34] = 32'h08000040;
    mem[40] = 32'hFC000000;
    mem[41] = 32'h8D090004;
    mem[255] = 32'h012A4020;
    mem[0] = 32'h08000040;
    ifc.start = 1'b0; ifc.base_addr = '0; ifc.count = '0; ifc.out_ready = 1'b1;
    ifc4.start = 1'b0; ifc4.base_addr = '0; ifc4.count = '0; ifc4.out_ready = 1'b1;

    #12;
    check("reset_state", out_vec(), 160'(0));
    step();
    rst_n = 1'b1;

    // Abort a run in WAIT.
    addr_q.push_back(32'd128);
    start_run(32'd128, 8'd3);
    step();
    nd = n_done;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait", out_vec(), 160'(0));
    step();
    step();
    check("no_done_after_abort", 160'(n_done), 160'(nd));
    queues_empty("abort");
    rst_n = 1'b1;
    step();

    // Basic three-word run: R, I, J.
    addr_q.push_back(32'd128); addr_q.push_back(32'd132); addr_q.push_back(32'd136);
    exp_q.push_back(w_r(32'd128)); exp_q.push_back(w_i(32'd132)); exp_q.push_back(w_j(32'd136));
    nd = n_done;
    start_run(32'd128, 8'd3);
    k = 0;
    while (!ifc.out_valid && k < 20) begin
      step();
      k++;
    end
    check("first_valid_lat1", 160'(k), 160'(3));
    wait_done("basic");
    check("basic_done_count", 160'(n_done - nd), 160'(1));
    queues_empty("basic");

    // Backpressure on an unknown-format word.
    ifc.out_ready = 1'b0;
    addr_q.push_back(32'd160); addr_q.push_back(32'd164);
    exp_q.push_back(w_u(32'd160)); exp_q.push_back(w_i(32'd164));
    start_run(32'd160, 8'd2);
    k = 0;
    while (!ifc.out_valid && k < 20) begin
      step();
      k++;
    end
    rd0 = n_reads;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 160'({ifc.out_valid, cur_word()}), 160'({1'b1, w_u(32'd160)}));
      step();
    end
    check("bp_no_fetch", 160'(n_reads), 160'(rd0));
    ifc.out_ready = 1'b1;
    wait_done("bp");
    queues_empty("bp");

    // count = 0: immediate done, no fetch.
    rd0 = n_reads;
    nd = n_done;
    start_run(32'd200, 8'd0);
    wait_done("zero");
    check("zero_no_fetch", 160'(n_reads), 160'(rd0));
    check("zero_done_count", 160'(n_done - nd), 160'(1));

    // Address wrap, with a start pulse issued while busy.
    addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0000_0000);
    exp_q.push_back(w_r(32'hFFFF_FFFC)); exp_q.push_back(w_j(32'h0000_0000));
    start_run(32'hFFFF_FFFC, 8'd2);
    step();
    check("busy_during_run", 160'(ifc.busy), 160'(1));
    step();
    ifc.start = 1'b1; ifc.base_addr = 32'd128; ifc.count = 8'd1;
    step();
    ifc.start = 1'b0;
    wait_done("wrap");
    queues_empty("wrap");

    // J word at 128 with target 0x40.
    mem[32] = 32'h08000040;
    mem[33] = 32'h012A4020;
    mem[64] = 32'h8D090004;
    addr_q.push_back(32'd128);
    exp_q.push_back(w_j(32'd128));
`ifdef FETCH_JUMP_FOLLOW_EN
    addr_q.push_back(32'h100);
    exp_q.push_back(w_i(32'h100));
`else
    addr_q.push_back(32'd132);
    exp_q.push_back(w_r(32'd132));
`endif
    start_run(32'd128, 8'd2);
    wait_done("jump");
    queues_empty("jump");

    // MEM_LAT = 4 instance: first out_valid six cycles after start.
    step();
    ifc4.start = 1'b1; ifc4.base_addr = 32'd128; ifc4.count = 8'd1;
    step();
    ifc4.start = 1'b0;
    k = 0;
    while (!ifc4.out_valid && k < 20) begin
      step();
      k++;
    end
    check("first_valid_lat4", 160'(k), 160'(6));
    check("lat4_pc", 160'(ifc4.pc_out), 160'(128));
    for (int i = 0; i < 20 && !ifc4.done; i++) step();
    check("lat4_done", 160'(ifc4.done), 160'(1));

    step();
    queues_empty("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
